rr_hold_arbiter: RTL and testbench

- Sequential round-robin arbiter that shares one multi-cycle resource (mux/shared bus port) among N requesters.
- Grants one requester at a time and holds that grant until the holder releases, drops its request, or exceeds a maximum hold time.
- Outputs are a one-hot grant plus its binary id, used directly as the one-hot select of the shared mux and as an index for status/logging.

---
 rtl/rr_hold_arbiter_pkg.sv | 17 +
 rtl/rr_hold_arbiter_pick.sv | 48 ++++
 rtl/rr_hold_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_hold_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rr_hold_arbiter_pkg.sv
// Shared definitions for the round-robin hold arbiter:
// FSM state encoding, default hold limit and id-width helper.
package rr_hold_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MAXHOLD_DEF = 8;

    // Minimum binary id width able to index n one-hot bits.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// Combinational round-robin winner select.
// Ports: req (N), ptr (M) in; pick (one-hot N), id (M) out.
module rr_pick
    import rr_hold_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 2
) (
    input  logic [N-1:0] req,
    input  logic [M-1:0] ptr,
    output logic [N-1:0] pick,
    output logic [M-1:0] id
);

    logic [N-1:0] rot;
    logic [N-1:0] first;
    logic [M-1:0] k;

    // Modulo-N wrap for indices below 2N.
    function automatic int wrap(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    always_comb begin
        rot   = '0;
        first = '0;
        k     = '0;
        pick  = '0;
        id    = '0;
        // Rotate right by ptr so the top-priority bit lands at 0.
        for (int i = 0; i < N; i++) begin
            rot[i] = req[wrap(i + int'(ptr))];
        end
        // LSB-first first-one isolate.
        first = rot & (~rot + N'(1));
        // Encode and rotate back.
        for (int i = 0; i < N; i++) begin
            if (first[i]) begin
                k = M'(i);
            end
            pick[wrap(i + int'(ptr))] = first[i];
        end
        if (|rot) begin
            id = M'(wrap(int'(k) + int'(ptr)));
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter holding a grant until release, request drop or timeout.
// Ports: clk, rst_n, req[N], rel in; gnt[N], gnt_id[M], gnt_v, tout out (all registered).
module rr_hold_arbiter
    import rr_hold_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int M       = 2,
    parameter int MAXHOLD = MAXHOLD_DEF,
    parameter int CW      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         rel,
    output logic [N-1:0] gnt,
    output logic [M-1:0] gnt_id,
    output logic         gnt_v,
    output logic         tout
);

    localparam logic [CW-1:0] TLIM =
        CW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);

    state_t        state_q, state_d;
    logic [M-1:0]  ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [M-1:0]  id_q, id_d;
    logic          v_q, v_d;
    logic          tout_q, tout_d;

    logic [N-1:0]  pick;
    logic [M-1:0]  pick_id;
    logic [M-1:0]  pick_nxt;
    logic          any;
    logic          held;
    logic          to_hit;
    logic          release_c;

    rr_pick #(
        .N (N),
        .M (M)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .id   (pick_id)
    );

    assign any      = |req;
    assign held     = |(gnt_q & req);
    assign to_hit   = (MAXHOLD != 0) && (cnt_q == TLIM);
    assign pick_nxt = (pick_id == M'(N - 1)) ? '0 : pick_id + M'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        v_d       = v_q;
        tout_d    = 1'b0;
        release_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = BUSY;
                    gnt_d   = pick;
                    id_d    = pick_id;
                    v_d     = 1'b1;
                    ptr_d   = pick_nxt;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                release_c = rel | ~held | to_hit;
                if (release_c) begin
                    cnt_d = '0;
                    if (any) begin
                        // Back-to-back handover, no idle bubble.
                        gnt_d  = pick;
                        id_d   = pick_id;
                        v_d    = 1'b1;
                        ptr_d  = pick_nxt;
                        tout_d = to_hit & ~rel & held;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                        v_d     = 1'b0;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            v_q     <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            v_q     <= v_d;
            tout_q  <= tout_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = id_q;
    assign gnt_v  = v_q;
    assign tout   = tout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (N=4, MAXHOLD=8).
// Vector table plus hand sequences for timeout and reset.
module tb_rr_hold_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_v;
    logic       tout;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0] req;
        logic       rel;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       v;
        logic       tout;
    } vec_t;

    vec_t tbl[12];

    rr_hold_arbiter #(
        .N       (4),
        .M       (2),
        .MAXHOLD (8),
        .CW      (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .rel    (rel),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .gnt_v  (gnt_v),
        .tout   (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eg,
                         input logic [1:0] eid, input logic ev,
                         input logic et);
        logic [7:0] got;
        logic [7:0] want;
        got  = {gnt, gnt_id, gnt_v, tout};
        want = {eg, eid, ev, et};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b id=%0d v=%b tout=%b, want gnt=%b id=%0d v=%b tout=%b",
                     name, gnt, gnt_id, gnt_v, tout, eg, eid, ev, et);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;

        //            req      rel   gnt      id     v     tout
        tbl[0]  = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[2]  = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[8]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[10] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

        #2;
        check("reset_init", 4'b0000, 2'd0, 1'b0, 1'b0);
        do_reset();
        check("post_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req;
            rel = tbl[i].rel;
            tick();
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id,
                  tbl[i].v, tbl[i].tout);
        end
        rel = 1'b0;

        // Timeout: bring ptr to 1 then hold req=0011.
        do_reset();
        req = 4'b0001;
        tick();
        check("to_setup", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        check("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("to_hold%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick();
        check("to_pulse", 4'b0001, 2'd0, 1'b1, 1'b1);
        // Holder 0 runs to its own timeout cycle.
        for (int c = 1; c < 8; c++) begin
            tick();
            check($sformatf("to_hold_b%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        // Coincident rel + drop + timeout: single release, no tout.
        req = 4'b0110;
        rel = 1'b1;
        tick();
        check("coincident", 4'b0010, 2'd1, 1'b1, 1'b0);
        rel = 1'b0;
        tick();
        check("coincident_hold", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-grant.
        do_reset();
        req = 4'b0100;
        tick();
        check("rst_setup", 4'b0100, 2'd2, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1000;
        #2;
        rst_n = 1'b1;
        tick();
        check("after_rst", 4'b1000, 2'd3, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
